// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - default rates and bit-clock increment helpers for the I2S transmitter
package i2s_pkg;

  localparam int DEF_CLK_RATE   = 32000000;
  localparam int DEF_AUDIO_RATE = 48000;
  localparam int DEF_AUDIO_DW   = 16;

  // Two BCK edges per bit, 2*dw bits per frame, so 4*dw ticks per sample period.
  function automatic longint calc_inc(input longint dw, input longint rate);
    return 4 * dw * rate;
  endfunction

  function automatic int calc_acc_w(input longint clk_rate, input longint inc);
    return $clog2(clk_rate + inc + 1);
  endfunction

endpackage

// File: rtl/i2s_tick_gen.sv
// rtl/i2s_tick_gen.sv - fractional accumulator producing the BCK half-period tick
module i2s_tick_gen import i2s_pkg::*; #(
  parameter int CLK_RATE = DEF_CLK_RATE,
  parameter int INC      = 3072000,
  parameter int ACC_W    = 32
) (
  input  logic clk_sys,
  input  logic reset_n,
  output logic tick
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;

  assign sum  = acc + ACC_W'(INC);
  assign tick = (sum >= ACC_W'(CLK_RATE));

  // Remainder is carried forward, so the long-term tick rate is exact.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (tick) begin
      acc <= sum - ACC_W'(CLK_RATE);
    end else begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - I2S stereo transmitter: sample hold, frame load and serialiser
module i2s_audio_tx import i2s_pkg::*; #(
  parameter int CLK_RATE   = DEF_CLK_RATE,
  parameter int AUDIO_RATE = DEF_AUDIO_RATE,
  parameter int AUDIO_DW   = DEF_AUDIO_DW
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic signed [AUDIO_DW-1:0] audio_l,
  input  logic signed [AUDIO_DW-1:0] audio_r,
  input  logic                       sample_valid,
  input  logic                       mute,
  output logic                       frame_start,
  output logic                       i2s_bck,
  output logic                       i2s_lrck,
  output logic                       i2s_data
);

  localparam int     FRAME_W = 2 * AUDIO_DW;
  localparam int     CNT_W   = $clog2(FRAME_W);
  localparam longint INC_L   = calc_inc(AUDIO_DW, AUDIO_RATE);
  localparam int     INC     = int'(INC_L);
  localparam int     ACC_W   = calc_acc_w(CLK_RATE, INC_L);

  if (INC_L >= CLK_RATE) begin : g_bad_rate
    $error("i2s_audio_tx: 4*AUDIO_DW*AUDIO_RATE must be below CLK_RATE");
  end

  logic                tick;
  logic [CNT_W-1:0]    bitcnt;
  logic [CNT_W-1:0]    bitcnt_nxt;
  logic [FRAME_W-1:0]  sr;
  logic [AUDIO_DW-1:0] hold_l;
  logic [AUDIO_DW-1:0] hold_r;

  i2s_tick_gen #(
    .CLK_RATE (CLK_RATE),
    .INC      (INC),
    .ACC_W    (ACC_W)
  ) u_tick_gen (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign bitcnt_nxt = (bitcnt == CNT_W'(FRAME_W - 1)) ? '0 : bitcnt + 1'b1;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hold_l <= '0;
      hold_r <= '0;
    end else if (sample_valid) begin
      hold_l <= audio_l;
      hold_r <= audio_r;
    end
  end

  // Everything except BCK itself moves on the falling BCK edge; the receiver samples on the rising one.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      i2s_bck     <= 1'b0;
      i2s_lrck    <= 1'b1;
      i2s_data    <= 1'b0;
      frame_start <= 1'b0;
      bitcnt      <= CNT_W'(FRAME_W - 1);
      sr          <= '0;
    end else begin
      frame_start <= 1'b0;
      if (tick) begin
        i2s_bck <= ~i2s_bck;
        if (i2s_bck) begin
          bitcnt   <= bitcnt_nxt;
          i2s_lrck <= (bitcnt_nxt >= CNT_W'(AUDIO_DW));
          i2s_data <= sr[FRAME_W-1];
          // Last right-channel bit goes out while the new frame loads: the I2S one-bit delay.
          if (bitcnt_nxt == '0) begin
            sr          <= mute ? '0 : {hold_l, hold_r};
            frame_start <= 1'b1;
          end else begin
            sr <= {sr[FRAME_W-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb/tb_i2s_audio_tx.sv - self-checking bench for i2s_audio_tx
module tb_i2s_audio_tx;

  localparam longint CLK1 = 32000000;
  localparam longint INC1 = 4 * 16 * 48000;
  localparam longint CLK2 = 27000000;
  localparam longint INC2 = 4 * 16 * 44100;
  localparam longint TPF  = 64;
  localparam int     WIN2 = 40000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rst2_n = 1'b0;
  logic [15:0] audio_l = '0, audio_r = '0;
  logic sample_valid = 1'b0, mute = 1'b0;
  logic fs, bck, lrck, data;
  logic [15:0] zl = '0, zr = '0;
  logic zsv = 1'b0, zmute = 1'b0;
  logic fs2, bck2, lrck2, data2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_audio_tx dut (
    .clk_sys(clk), .reset_n(reset_n), .audio_l(audio_l), .audio_r(audio_r),
    .sample_valid(sample_valid), .mute(mute), .frame_start(fs),
    .i2s_bck(bck), .i2s_lrck(lrck), .i2s_data(data)
  );

  i2s_audio_tx #(.CLK_RATE(27000000), .AUDIO_RATE(44100)) dut2 (
    .clk_sys(clk), .reset_n(rst2_n), .audio_l(zl), .audio_r(zr),
    .sample_valid(zsv), .mute(zmute), .frame_start(fs2),
    .i2s_bck(bck2), .i2s_lrck(lrck2), .i2s_data(data2)
  );

  // Reference model: hold value and mute as seen just before each clk edge.
  longint edge_cnt = 0;
  logic [31:0] hold_m = '0, snap = '0;
  logic snap_mute = 1'b0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt <= 0; hold_m <= '0; snap <= '0; snap_mute <= 1'b0;
    end else begin
      edge_cnt  <= edge_cnt + 1;
      snap      <= hold_m;
      snap_mute <= mute;
      if (sample_valid) hold_m <= {audio_l, audio_r};
    end
  end

  // I2S receiver: sample on BCK rise, word boundaries from LRCK falling.
  logic [31:0] exp_mem [0:511];
  logic [31:0] rx_mem [0:511];
  int exp_wr = 0, rx_wr = 0, exp_rd = 0, rx_rd = 0;
  logic prev_bck = 1'b0, prev_lrck = 1'b1, collecting = 1'b0;
  logic [31:0] rx_sh = '0;
  int rx_n = 0, frame_err = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_bck <= 1'b0; prev_lrck <= 1'b1; collecting <= 1'b0; rx_n <= 0;
    end else begin
      prev_bck <= bck;
      if (fs) begin
        exp_mem[exp_wr] <= snap_mute ? 32'h0 : snap;
        exp_wr <= exp_wr + 1;
      end
      if (bck && !prev_bck) begin
        prev_lrck <= lrck;
        if (prev_lrck && !lrck) begin
          if (collecting) begin
            if (rx_n == 31) begin
              rx_mem[rx_wr] <= {rx_sh[30:0], data};
              rx_wr <= rx_wr + 1;
            end else frame_err <= frame_err + 1;
          end
          collecting <= 1'b1; rx_n <= 0;
        end else if (collecting) begin
          rx_sh <= {rx_sh[30:0], data};
          rx_n  <= rx_n + 1;
        end
      end
    end
  end

  // Second instance: toggle count, frame count and BCK phase lengths over a window.
  int n2 = 0, tog2 = 0, frames2 = 0, run2 = 0;
  int hi_min = 1000, hi_max = 0, lo_min = 1000, lo_max = 0;
  logic prev_bck2 = 1'b0, seen2 = 1'b0, done2 = 1'b0;
  always @(negedge clk) begin
    if (rst2_n) begin
      if (n2 < WIN2) begin
        n2 <= n2 + 1;
        if (fs2) frames2 <= frames2 + 1;
        if (bck2 != prev_bck2) begin
          tog2 <= tog2 + 1;
          if (seen2) begin
            if (prev_bck2) begin
              if (run2 < hi_min) hi_min <= run2;
              if (run2 > hi_max) hi_max <= run2;
            end else begin
              if (run2 < lo_min) lo_min <= run2;
              if (run2 > lo_max) lo_max <= run2;
            end
          end
          seen2 <= 1'b1; run2 <= 1;
        end else run2 <= run2 + 1;
        prev_bck2 <= bck2;
      end else done2 <= 1'b1;
    end
  end

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        m;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [5];

  function automatic longint load_edge(input longint n, input longint cr, input longint inc);
    return ((2 + TPF * n) * cr + inc - 1) / inc;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_fs(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!fs && n < 3000);
    if (!fs) chk({name, "_fs_timeout"}, 0, 1);
  endtask

  task automatic wait_rx(input int target, input string name);
    int n;
    n = 0;
    while (rx_wr < target && n < 4000) begin @(negedge clk); n++; end
    if (rx_wr < target) chk({name, "_rx_timeout"}, rx_wr, target);
  endtask

  task automatic drain();
    while (rx_rd < rx_wr) begin
      if (exp_rd >= exp_wr) chk("sb_underflow", rx_mem[rx_rd], 64'hdead);
      else begin
        chk("sb_word", rx_mem[rx_rd], exp_mem[exp_rd]);
        exp_rd++;
      end
      rx_rd++;
    end
  endtask

  task automatic drive(input logic [15:0] l, input logic [15:0] r, input logic m);
    audio_l = l; audio_r = r; mute = m; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  initial begin
    int cnt, pos3, rises, base, n, falls, spread, lo, hi;
    longint le, ln, t2, f2;
    logic pb;
    logic [31:0] prev;

    tbl[0] = '{16'h8001, 16'h7FFE, 1'b0, 32'h80017FFE};
    tbl[1] = '{16'h1234, 16'hABCD, 1'b0, 32'h1234ABCD};
    tbl[2] = '{16'hFFFF, 16'h0000, 1'b1, 32'h00000000};
    tbl[3] = '{16'h0001, 16'h8000, 1'b0, 32'h00018000};
    tbl[4] = '{16'h5A5A, 16'hA5A5, 1'b0, 32'h5A5AA5A5};

    repeat (3) @(negedge clk);
    chk("rst_bck", bck, 0);
    chk("rst_lrck", lrck, 1);
    chk("rst_data", data, 0);
    chk("rst_fs", fs, 0);
    #1 reset_n = 1'b1; rst2_n = 1'b1;

    wait_fs("first");
    chk("first_fs_edge", edge_cnt, load_edge(0, CLK1, INC1));
    chk("first_lrck", lrck, 0);

    // Frame timing over 2000 clk after the first load.
    cnt = 0; pos3 = 0; rises = 0; pb = bck;
    for (int t = 1; t <= 2000; t++) begin
      @(negedge clk);
      if (fs) begin cnt++; if (cnt == 3) pos3 = t; end
      if (bck && !pb) rises++;
      pb = bck;
    end
    chk("fs_count_2000", cnt, 3);
    chk("fs3_pos_ok", (pos3 >= 1999 && pos3 <= 2001), 1);
    chk("bck_periods_2000", rises, 96);
    drain();

    // Table vectors: new value lands in the next frame; the frame in progress keeps the previous one.
    prev = 32'h0;
    for (int i = 0; i < 5; i++) begin
      wait_fs("tbl");
      repeat ($urandom_range(400, 50)) @(negedge clk);
      base = rx_wr;
      drive(tbl[i].l, tbl[i].r, tbl[i].m);
      wait_rx(base + 2, "tbl");
      chk($sformatf("tbl%0d_cur", i), rx_mem[base], prev);
      chk($sformatf("tbl%0d_next", i), rx_mem[base + 1], tbl[i].exp);
      prev = tbl[i].exp;
      drain();
    end

    // Randomized samples and mute against the reference model.
    for (int i = 0; i < 12; i++) begin
      wait_fs("rnd");
      repeat ($urandom_range(500, 30)) @(negedge clk);
      if ($urandom_range(3, 0) != 0)
        drive(16'($urandom), 16'($urandom), ($urandom_range(3, 0) == 0));
      drain();
    end

    // sample_valid on the load clk: old value this frame, new value next frame.
    wait_fs("coin_pre");
    repeat (100) @(negedge clk);
    drive(16'hAAAA, 16'h5555, 1'b0);
    base = rx_wr;
    wait_rx(base + 2, "coin_pre");
    n = 0;
    while (load_edge(n, CLK1, INC1) < edge_cnt + 2) n++;
    le = load_edge(n, CLK1, INC1);
    while (edge_cnt < le - 1) @(negedge clk);
    audio_l = 16'h1234; audio_r = 16'h1234; sample_valid = 1'b1;
    base = rx_wr;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("coin_fs_edge", fs, 1);
    wait_rx(base + 3, "coin");
    chk("coin_old_frame", rx_mem[base + 1], 32'hAAAA5555);
    chk("coin_new_frame", rx_mem[base + 2], 32'h12341234);
    drain();

    // Reset mid-frame at bitcnt 7.
    drive(16'hFFFF, 16'hFFFF, 1'b0);
    base = rx_wr;
    wait_rx(base + 2, "rst_pre");
    drain();
    wait_fs("rst_mid");
    falls = 0; n = 0; pb = bck;
    while (falls < 7 && n < 2000) begin
      @(negedge clk); n++;
      if (pb && !bck) falls++;
      pb = bck;
    end
    while (!bck && n < 2000) begin @(negedge clk); n++; end
    chk("pre_rst_bck", bck, 1);
    chk("pre_rst_lrck", lrck, 0);
    chk("pre_rst_data", data, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_bck", bck, 0);
    chk("mid_rst_lrck", lrck, 1);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_fs", fs, 0);
    repeat (3) @(negedge clk);
    rx_rd = rx_wr; exp_rd = exp_wr;
    #1 reset_n = 1'b1;
    wait_fs("post_rst");
    chk("post_rst_fs_edge", edge_cnt, load_edge(0, CLK1, INC1));
    base = rx_wr;
    wait_rx(base + 2, "post_rst");
    drain();
    chk("frame_err", frame_err, 0);

    // 27 MHz / 44.1 kHz instance.
    n = 0;
    while (!done2 && n < 60000) begin @(negedge clk); n++; end
    chk("dut2_done", done2, 1);
    t2 = (longint'(WIN2) * INC2) / CLK2;
    f2 = (t2 >= 2) ? (t2 - 2) / TPF + 1 : 0;
    chk("dut2_ticks", tog2, t2);
    chk("dut2_frames", frames2, f2);
    lo = (hi_min < lo_min) ? hi_min : lo_min;
    hi = (hi_max > lo_max) ? hi_max : lo_max;
    spread = hi - lo;
    chk("dut2_phase_spread_ok", (spread >= 0 && spread <= 1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_audio_tx.md
I2S_AUDIO_TX -- requirements
Module: i2s_audio_tx

Interface
REQ-001 SHALL have parameter CLK_RATE, default 32000000, meaning clk_sys frequency in Hz.
REQ-002 SHALL have parameter AUDIO_RATE, default 48000, meaning output sample rate fs in Hz.
REQ-003 SHALL have parameter AUDIO_DW, default 16, meaning bits per channel; the frame is 2*AUDIO_DW bits.
REQ-004 SHALL have port clk_sys, input, 1 bit, sole clock; all logic sits on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port audio_l, input, AUDIO_DW bits, signed left sample.
REQ-007 SHALL have port audio_r, input, AUDIO_DW bits, signed right sample.
REQ-008 SHALL have port sample_valid, input, 1 bit; when high, audio_l/audio_r are captured into the hold registers.
REQ-009 SHALL have port mute, input, 1 bit; when high, frames load all-zero data.
REQ-010 SHALL have port frame_start, output, 1 bit, one-clk pulse on each frame load.
REQ-011 SHALL have port i2s_bck, output, 1 bit, bit clock.
REQ-012 SHALL have port i2s_lrck, output, 1 bit, word select; 0 = left, 1 = right.
REQ-013 SHALL have port i2s_data, output, 1 bit, serial data, MSB first.

Function
REQ-014 SHALL generate the tick with a fractional accumulator: each clk adds INC = 4*AUDIO_DW*AUDIO_RATE; when the sum is >= CLK_RATE, subtract CLK_RATE and assert tick for one clk.
REQ-015 SHALL size the accumulator to hold CLK_RATE+INC without overflow; the 32-bit default is sufficient.
REQ-016 SHALL toggle i2s_bck on every tick, so f_bck = 2*AUDIO_DW*fs, with no drift over time.
REQ-017 SHALL perform all lrck, data and bit-counter updates only on ticks that drive i2s_bck from 1 to 0 (falling edge).
REQ-018 On each falling edge, bitcnt (0..2*AUDIO_DW-1) SHALL increment modulo 2*AUDIO_DW.
REQ-019 On each falling edge, i2s_lrck SHALL become (new bitcnt >= AUDIO_DW).
REQ-020 On the falling edge where bitcnt wraps to 0, the block SHALL output the old sr MSB on i2s_data, load sr = {hold_l, hold_r} (or 0 when mute is high), and pulse frame_start.
REQ-021 On all other falling edges, the block SHALL drive i2s_data <= sr MSB and shift sr left by one.
REQ-022 The left MSB SHALL appear one BCK after lrck falls, and the right LSB SHALL appear at bitcnt 0 of the next frame (standard I2S one-bit delay).
REQ-023 sample_valid SHALL update the hold registers on any clk, including the frame-load clk.
REQ-024 The frame load SHALL use the hold values registered before that clk; a coincident sample_valid applies to the next frame.
REQ-025 With no sample_valid, the last held sample SHALL repeat every frame; there is no underrun flag.
REQ-026 mute SHALL be sampled only at frame load; a frame in progress completes unchanged.
REQ-027 A parameter check SHALL fail elaboration unless INC < CLK_RATE.

Reset
REQ-028 While reset_n is low, outputs SHALL hold: i2s_bck=0, i2s_lrck=1, i2s_data=0, frame_start=0.
REQ-029 While reset_n is low, internal state SHALL be: accumulator=0, bitcnt=2*AUDIO_DW-1, sr=0, hold_l=hold_r=0.
REQ-030 After release, the first frame SHALL load on the 2nd tick; i2s_lrck 1->0 occurs at that point.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately with no glitch beyond returning outputs to reset values.

Structure
REQ-032 Package i2s_pkg SHALL hold the default rate constants and a function computing INC and accumulator width.
REQ-033 Sub-module i2s_tick_gen (fractional accumulator, tick output) SHALL be instantiated once.
REQ-034 Remaining logic SHALL stay flat in i2s_audio_tx.

Verification
REQ-035 Defaults, 2000 clk after the first frame_start -> exactly 3 further frame_start pulses, with the 3rd at clk 2000 ±1; 96 BCK periods.
REQ-036 audio_l=16'h8001, audio_r=16'h7FFE held -> data after lrck falls = 1000000000000001, then after lrck rises 0111111111111110 (LSB at next bitcnt 0).
REQ-037 sample_valid on the same clk as frame_start with new value 16'h1234 -> current frame carries the old value and the next frame carries 16'h1234.
REQ-038 mute=1 asserted mid-frame -> current frame completes with data; next frame all zeros on both channels.
REQ-039 reset_n pulsed low at bitcnt 7 -> i2s_bck=0, i2s_lrck=1, i2s_data=0 asynchronously; after release the first frame_start comes on the 2nd tick.
REQ-040 CLK_RATE=27000000, AUDIO_RATE=44100 -> 44100 frames within 27000000 ±1 clk, with bck high/low phase lengths differing by at most 1 clk.
